// File: rtl/flag_context_stack.sv
// flag_context_stack
//   Save/restore stack for the SAYEH carry and zero flags. The controller
//   pushes the current {C,Z} from the status register when a context is
//   entered and pops it on return; a pop drives the restored flags onto
//   Cin/Zin together with a one-cycle SRload strobe for the status register.
//
//   Optional feature macro: FLAG_STACK_ERR_EN
//     defined   - sticky ovf/unf error flags, cleared by clrErr
//     undefined - ovf/unf tied low, clrErr ignored
//
// Parameters:
//   DEPTH   number of {C,Z} entries (2..64)
//   CW      occupancy count width, derived from DEPTH
//
// Ports:
//   clk     system clock, rising edge
//   resetN  asynchronous active-low reset
//   Cflag   current carry flag from the status register
//   Zflag   current zero flag from the status register
//   push    save {Cflag,Zflag} (single-cycle request)
//   pop     restore the top entry (single-cycle request)
//   clrErr  clear sticky error flags
//   Cin     restored carry value (registered)
//   Zin     restored zero value (registered)
//   SRload  one-cycle status register load strobe per accepted pop
//   full    count == DEPTH
//   empty   count == 0
//   count   number of stored entries
//   ovf     sticky: push attempted while full
//   unf     sticky: pop attempted while empty
module flag_context_stack #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          Cflag,
    input  logic          Zflag,
    input  logic          push,
    input  logic          pop,
    input  logic          clrErr,
    output logic          Cin,
    output logic          Zin,
    output logic          SRload,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    mem [DEPTH];
    logic [CW-1:0] count_q;
    logic          is_empty;
    logic          is_full;
    logic          pop_acc;
    logic          push_acc;
    logic          swap;
    logic          pop_only;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          wr_en;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // Push together with pop on a non-empty stack is a swap; on an empty
    // stack the pop is not accepted and the request degrades to a push.
    assign pop_acc  = pop & ~is_empty;
    assign swap     = pop_acc & push;
    assign pop_only = pop_acc & ~push;
    assign push_acc = push & ~pop_acc & ~is_full;

    assign top_idx = AW'(count_q - CW'(1));

    always_comb begin
        wr_en  = push_acc | swap;
        wr_idx = swap ? top_idx : AW'(count_q);
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (resetN && wr_en) begin
            mem[wr_idx] <= {Cflag, Zflag};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
            Cin     <= 1'b0;
            Zin     <= 1'b0;
            SRload  <= 1'b0;
        end else begin
            SRload <= pop_acc;
            if (pop_acc) begin
                {Cin, Zin} <= mem[top_idx];
            end
            if (push_acc) begin
                count_q <= count_q + CW'(1);
            end else if (pop_only) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign full  = is_full;
    assign empty = is_empty;
    assign count = count_q;

`ifdef FLAG_STACK_ERR_EN
    logic ovf_evt;
    logic unf_evt;
    logic ovf_q;
    logic unf_q;

    assign ovf_evt = push & ~pop & is_full;
    assign unf_evt = pop & ~push & is_empty;

    // A new error event takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (clrErr) begin
                ovf_q <= 1'b0;
            end
            if (unf_evt) begin
                unf_q <= 1'b1;
            end else if (clrErr) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    logic unused_clr;

    assign unused_clr = clrErr;
    assign ovf        = 1'b0;
    assign unf        = 1'b0;
`endif

endmodule
